// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared types and helpers for the iterative multiplier
package mul_pkg;

  // Widest operand abs_ext can handle; the top rejects anything larger.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // value must arrive sign-extended to MAX_W when signed_mode is set; the
  // low WIDTH bits of the result are the operand magnitude.
  function automatic logic [MAX_W-1:0] abs_ext(input logic [MAX_W-1:0] value,
                                               input logic             signed_mode);
    logic [MAX_W-1:0] mag;
    mag = value;
    if (signed_mode && value[MAX_W-1]) begin
      mag = ~value + {{(MAX_W-1){1'b0}}, 1'b1};
    end
    return mag;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - operand/product handshake bundle for seq_multiplier
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;

  modport master (
    output in_valid, in1, in2, signed_mode, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in1, in2, signed_mode, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier, WIDTH steps per product
// Signed operands are reduced to magnitudes up front and the sign reapplied at the end.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_multiplier_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  generate
    if (WIDTH < 2) begin : g_width_too_small
      $error("seq_multiplier: WIDTH must be at least 2");
    end
    if (WIDTH > MAX_W) begin : g_width_too_large
      $error("seq_multiplier: WIDTH exceeds mul_pkg::MAX_W");
    end
  endgenerate

  mul_state_e       state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [PW-1:0]    out_q, out_d;

  logic [MAX_W-1:0] in1_ext, in2_ext;
  logic [MAX_W-1:0] in1_mag, in2_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic             last_step;

  always_comb begin
    in1_ext = bus.signed_mode ? MAX_W'($signed(bus.in1)) : MAX_W'(bus.in1);
    in2_ext = bus.signed_mode ? MAX_W'($signed(bus.in2)) : MAX_W'(bus.in2);
    in1_mag = abs_ext(in1_ext, bus.signed_mode);
    in2_mag = abs_ext(in2_ext, bus.signed_mode);
  end

  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    acc_sum   = acc_q + addend;
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    out_d    = out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = PW'(in1_mag[WIDTH-1:0]);
          mplier_d = in2_mag[WIDTH-1:0];
          sign_d   = bus.signed_mode & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[PW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          out_d   = sign_q ? (~acc_sum + PW'(1)) : acc_sum;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      out_q    <= out_d;
    end
  end

  // Handshake flags decode the state register only, so no input reaches them combinationally.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier (WIDTH 8 and 16)
module tb_seq_multiplier;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seq_multiplier_if #(.WIDTH(8))  b8 ();
  seq_multiplier_if #(.WIDTH(16)) b16 ();

  seq_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
  seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as integers, multiply, keep the low 2*w bits.
  function automatic longint unsigned model(input int w, input longint unsigned a,
                                            input longint unsigned b, input bit sm);
    longint sa, sb, p;
    longint unsigned half, full;
    half = longint'(1) << (w - 1);
    full = longint'(1) << w;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a >= half) sa = sa - longint'(full);
    if (sm && b >= half) sb = sb - longint'(full);
    p = sa * sb;
    return longint'(p) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  function automatic bit get_ready(input int w);
    return (w == 8) ? b8.in_ready : b16.in_ready;
  endfunction

  function automatic bit get_valid(input int w);
    return (w == 8) ? b8.out_valid : b16.out_valid;
  endfunction

  function automatic longint unsigned get_out(input int w);
    return (w == 8) ? longint'(b8.out) : longint'(b16.out);
  endfunction

  task automatic set_in(input int w, input bit v, input longint unsigned a,
                        input longint unsigned b, input bit sm);
    if (w == 8) begin
      b8.in_valid = v; b8.in1 = a[7:0]; b8.in2 = b[7:0]; b8.signed_mode = sm;
    end else begin
      b16.in_valid = v; b16.in1 = a[15:0]; b16.in2 = b[15:0]; b16.signed_mode = sm;
    end
  endtask

  // Presents one operation, returns the product and the cycles from acceptance to out_valid.
  task automatic run_op(input int w, input longint unsigned a, input longint unsigned b,
                        input bit sm, output longint unsigned res, output int lat);
    for (int i = 0; i < 50 && !get_ready(w); i++) begin
      @(posedge clk); #1;
    end
    set_in(w, 1'b1, a, b, sm);
    @(posedge clk); #1;
    set_in(w, 1'b0, 0, 0, 1'b0);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (get_valid(w)) break;
    end
    if (!get_valid(w)) lat = -1;
    res = get_out(w);
  endtask

  task automatic handshake(input int w);
    if (w == 8) b8.out_ready = 1'b1; else b16.out_ready = 1'b1;
    @(posedge clk); #1;
    if (w == 8) b8.out_ready = 1'b0; else b16.out_ready = 1'b0;
  endtask

  task automatic op_check(input string name, input int w, input longint unsigned a,
                          input longint unsigned b, input bit sm, input longint unsigned exp);
    longint unsigned res;
    int lat;
    run_op(w, a, b, sm, res, lat);
    checks++;
    if (lat !== w) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, w);
    end
    checks++;
    if (res !== exp) begin
      failures++;
      $display("FAIL %s product: got 0x%0h expected 0x%0h", name, res, exp);
    end
    handshake(w);
    checks++;
    if (get_ready(w) !== 1'b1 || get_valid(w) !== 1'b0) begin
      failures++;
      $display("FAIL %s post-handshake: in_ready=%0b out_valid=%0b expected 1/0",
               name, get_ready(w), get_valid(w));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(8, 1'b0, 0, 0, 1'b0);
    set_in(16, 1'b0, 0, 0, 1'b0);
    b8.out_ready = 1'b0;
    b16.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.out !== 16'h0) begin
      failures++;
      $display("FAIL reset8: in_ready=%0b out_valid=%0b out=0x%0h expected 1/0/0",
               b8.in_ready, b8.out_valid, b8.out);
    end
    checks++;
    if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0 || b16.out !== 32'h0) begin
      failures++;
      $display("FAIL reset16: in_ready=%0b out_valid=%0b out=0x%0h expected 1/0/0",
               b16.in_ready, b16.out_valid, b16.out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    op_check("u15x15", 8, 15, 15, 1'b0, 64'h00E1);
    op_check("u255x255", 8, 255, 255, 1'b0, 64'hFE01);
    op_check("u0x200", 8, 0, 200, 1'b0, 64'h0000);
    for (int i = 0; i < 6; i++) begin
      longint unsigned a, b;
      a = $urandom_range(255);
      b = $urandom_range(255);
      op_check("u8rand", 8, a, b, 1'b0, model(8, a, b, 1'b0));
    end
  endtask

  task automatic test_signed();
    op_check("s-3x5", 8, 8'hFD, 5, 1'b1, 64'hFFF1);
    op_check("s-128x-128", 8, 8'h80, 8'h80, 1'b1, 64'h4000);
    op_check("s-128x127", 8, 8'h80, 8'h7F, 1'b1, 64'hC080);
    for (int i = 0; i < 6; i++) begin
      longint unsigned a, b;
      a = $urandom_range(255);
      b = $urandom_range(255);
      op_check("s8rand", 8, a, b, 1'b1, model(8, a, b, 1'b1));
    end
  endtask

  task automatic test_backpressure();
    longint unsigned res, held;
    int lat;
    bit bad;
    run_op(8, 37, 8'hFE, 1'b1, res, lat);
    checks++;
    if (lat !== 8 || res !== model(8, 37, 8'hFE, 1'b1)) begin
      failures++;
      $display("FAIL bp_first: got 0x%0h lat %0d expected 0x%0h lat 8",
               res, lat, model(8, 37, 8'hFE, 1'b1));
    end
    held = res;
    bad = 1'b0;
    set_in(8, 1'b1, 11, 13, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0 || longint'(b8.out) !== held) bad = 1'b1;
    end
    set_in(8, 1'b0, 0, 0, 1'b0);
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_stall: out=0x%0h out_valid=%0b in_ready=%0b expected 0x%0h/1/0",
               b8.out, b8.out_valid, b8.in_ready, held);
    end
    handshake(8);
    // Stalled operands must not have started a computation.
    @(posedge clk); #1;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || longint'(b8.out) !== held) begin
      failures++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b out=0x%0h expected 1/0/0x%0h",
               b8.in_ready, b8.out_valid, b8.out, held);
    end
    op_check("bp_next", 8, 200, 3, 1'b0, 64'd600);
  endtask

  task automatic test_reset_mid();
    bit bad;
    set_in(8, 1'b1, 100, 100, 1'b0);
    @(posedge clk); #1;
    set_in(8, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (b8.out !== 16'h0 || b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid: out=0x%0h out_valid=%0b in_ready=%0b expected 0/0/1",
               b8.out, b8.out_valid, b8.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (b8.out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL rst_stale: out_valid seen after reset, expected none");
    end
    op_check("rst_7x6", 8, 7, 6, 1'b0, 64'd42);
  endtask

  task automatic test_sweep16();
    for (int i = 0; i < 30; i++) begin
      longint unsigned a, b;
      bit sm;
      a  = $urandom_range(65535);
      b  = $urandom_range(65535);
      sm = $urandom_range(1);
      if (i == 0) begin a = 16'h8000; b = 16'h8000; sm = 1'b1; end
      if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; sm = 1'b0; end
      op_check(sm ? "w16s" : "w16u", 16, a, b, sm, model(16, a, b, sm));
    end
  endtask

  task automatic test_back_to_back();
    longint unsigned res;
    int lat;
    int start_t;
    b8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      longint unsigned a, b;
      a = $urandom_range(255);
      b = $urandom_range(255);
      run_op(8, a, b, 1'b1, res, lat);
      checks++;
      if (lat !== 8 || res !== model(8, a, b, 1'b1)) begin
        failures++;
        $display("FAIL b2b: got 0x%0h lat %0d expected 0x%0h lat 8", res, lat, model(8, a, b, 1'b1));
      end
      @(posedge clk); #1;
    end
    b8.out_ready = 1'b0;
    start_t = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_sweep16();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
